// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the DSO ADC front end: sample strobe, circular pre/post
// trigger buffer addressing, trigger selection and bank handoff to SPI readout.
module adc_capture_ctrl #(
   parameter int DEPTH  = 11,
   parameter int DEL_W  = 24,
   parameter int NCH    = 4,
   parameter int CH_W   = 2,
   parameter int AUTO_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DEL_W-1:0]  sample_divider,
   input  logic [1:0]        mode,
   input  logic [DEPTH-1:0]  pre_count,
   input  logic [AUTO_W-1:0] auto_timeout,
   input  logic [NCH-1:0]    trigger_req,
   input  logic [CH_W-1:0]   trig_sel,
   input  logic              arm,
   input  logic              ready,
   output logic              valid,
   output logic [DEPTH-1:0]  mem_addr,
   output logic              mem_en,
   output logic [DEPTH-1:0]  trig_addr,
   output logic [DEPTH-1:0]  start_addr,
   output logic              bank_sel,
   output logic [2:0]        trigger_state,
   output logic              waiting_for_trigger,
   output logic              triggered,
   output logic              auto_fired
);

   // state     | meaning
   // IDLE      | single mode, capture done; waits for arm
   // PREBUF    | writes the pre_q samples that must precede any trigger
   // WAIT_TRIG | circular writes until the trigger condition on a strobe
   // FILL      | writes the N-1-pre_q post-trigger samples
   // READ      | bank complete, valid high until ready
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PREBUF    = 3'd1,
      WAIT_TRIG = 3'd2,
      FILL      = 3'd3,
      READ      = 3'd4
   } state_t;

   state_t             state, state_d;
   logic [DEL_W-1:0]   div_q;
   logic [NCH-1:0]     req_q;
   logic [DEPTH-1:0]   addr, addr_d;
   logic [DEPTH-1:0]   pre_cnt, pre_cnt_d;
   logic [DEPTH-1:0]   pre_q, pre_q_d;
   logic               pre_ld, pre_ld_d;
   logic [DEPTH-1:0]   post_cnt, post_cnt_d;
   logic [AUTO_W-1:0]  auto_cnt, auto_cnt_d;
   logic [DEPTH-1:0]   trig_addr_d;
   logic               bank_sel_d;
   logic               auto_fired_d;

   logic               sample_strobe;
   logic               sel_req;
   logic               auto_term;
   logic               trigger_flag;
   logic [DEPTH-1:0]   pre_eff;
   logic [DEPTH-1:0]   post_tgt;
   logic [DEPTH-1:0]   addr_inc;
   logic [DEPTH-1:0]   pre_cnt_inc;
   logic [DEPTH-1:0]   post_cnt_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         req_q <= '0;
      end else begin
         div_q <= (div_q == '0) ? sample_divider : div_q - 1'b1;
         req_q <= trigger_req;
      end
   end

   assign sample_strobe = (div_q == '0);

   always_comb begin
      sel_req = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (trig_sel == CH_W'(i)) sel_req = req_q[i];
      end
   end

   assign auto_term    = (mode == 2'd1) && (auto_cnt == auto_timeout);
   assign trigger_flag = sel_req | (mode == 2'd2) | auto_term;
   // pre_count is latched on the first PREBUF cycle, so that cycle uses it directly
   assign pre_eff      = pre_ld ? pre_count : pre_q;
   assign post_tgt     = ~pre_q;
   assign addr_inc     = addr + 1'b1;
   assign pre_cnt_inc  = pre_cnt + 1'b1;
   assign post_cnt_inc = post_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= PREBUF;
         addr       <= '0;
         pre_cnt    <= '0;
         pre_q      <= '0;
         pre_ld     <= 1'b1;
         post_cnt   <= '0;
         auto_cnt   <= '0;
         trig_addr  <= '0;
         bank_sel   <= 1'b0;
         auto_fired <= 1'b0;
      end else begin
         state      <= state_d;
         addr       <= addr_d;
         pre_cnt    <= pre_cnt_d;
         pre_q      <= pre_q_d;
         pre_ld     <= pre_ld_d;
         post_cnt   <= post_cnt_d;
         auto_cnt   <= auto_cnt_d;
         trig_addr  <= trig_addr_d;
         bank_sel   <= bank_sel_d;
         auto_fired <= auto_fired_d;
      end
   end

   always_comb begin
      state_d      = state;
      addr_d       = addr;
      pre_cnt_d    = pre_cnt;
      pre_q_d      = pre_q;
      pre_ld_d     = pre_ld;
      post_cnt_d   = post_cnt;
      auto_cnt_d   = auto_cnt;
      trig_addr_d  = trig_addr;
      bank_sel_d   = bank_sel;
      auto_fired_d = auto_fired;
      mem_en       = 1'b0;
      valid        = 1'b0;
      case (state)
         IDLE: begin
            if (arm) begin
               state_d   = PREBUF;
               addr_d    = '0;
               pre_cnt_d = '0;
               pre_ld_d  = 1'b1;
            end
         end
         PREBUF: begin
            if (pre_ld) begin
               pre_q_d  = pre_count;
               pre_ld_d = 1'b0;
            end
            if (pre_cnt == pre_eff) begin
               state_d    = WAIT_TRIG;
               auto_cnt_d = '0;
            end else if (sample_strobe) begin
               mem_en    = 1'b1;
               addr_d    = addr_inc;
               pre_cnt_d = pre_cnt_inc;
               if (pre_cnt_inc == pre_eff) begin
                  state_d    = WAIT_TRIG;
                  auto_cnt_d = '0;
               end
            end
         end
         WAIT_TRIG: begin
            if (sample_strobe) begin
               mem_en = 1'b1;
               addr_d = addr_inc;
               if (trigger_flag) begin
                  state_d      = FILL;
                  trig_addr_d  = addr;
                  post_cnt_d   = '0;
                  auto_fired_d = auto_term & ~sel_req & (mode != 2'd2);
               end else if (auto_cnt != '1) begin
                  auto_cnt_d = auto_cnt + 1'b1;
               end
            end
         end
         FILL: begin
            // leave on the last write so valid follows it by one cycle
            if (post_cnt == post_tgt) begin
               state_d = READ;
            end else if (sample_strobe) begin
               mem_en     = 1'b1;
               addr_d     = addr_inc;
               post_cnt_d = post_cnt_inc;
               if (post_cnt_inc == post_tgt) state_d = READ;
            end
         end
         READ: begin
            valid = 1'b1;
            if (ready) begin
               bank_sel_d = ~bank_sel;
               if (mode == 2'd3) begin
                  state_d = IDLE;
               end else begin
                  state_d   = PREBUF;
                  addr_d    = '0;
                  pre_cnt_d = '0;
                  pre_ld_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d   = PREBUF;
            addr_d    = '0;
            pre_cnt_d = '0;
            pre_ld_d  = 1'b1;
         end
      endcase
   end

   assign mem_addr            = addr;
   assign start_addr          = trig_addr - pre_q;
   assign trigger_state       = state;
   assign waiting_for_trigger = (state == WAIT_TRIG);
   assign triggered           = (state == FILL) || (state == READ);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: scoreboarded captures across modes,
// single-mode idle/arm, divider strobe spacing, unreachable trigger select, reset abort.
module tb_adc_capture_ctrl;
   localparam int DEPTH  = 4;
   localparam int DEL_W  = 8;
   localparam int NCH    = 3;
   localparam int CH_W   = 2;
   localparam int AUTO_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DEL_W-1:0]  sample_divider;
   logic [1:0]        mode;
   logic [DEPTH-1:0]  pre_count;
   logic [AUTO_W-1:0] auto_timeout;
   logic [NCH-1:0]    trigger_req;
   logic [CH_W-1:0]   trig_sel;
   logic              arm;
   logic              ready;
   logic              valid;
   logic [DEPTH-1:0]  mem_addr;
   logic              mem_en;
   logic [DEPTH-1:0]  trig_addr;
   logic [DEPTH-1:0]  start_addr;
   logic              bank_sel;
   logic [2:0]        trigger_state;
   logic              waiting_for_trigger;
   logic              triggered;
   logic              auto_fired;

   adc_capture_ctrl #(
      .DEPTH(DEPTH), .DEL_W(DEL_W), .NCH(NCH), .CH_W(CH_W), .AUTO_W(AUTO_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sample_divider(sample_divider), .mode(mode),
      .pre_count(pre_count), .auto_timeout(auto_timeout), .trigger_req(trigger_req),
      .trig_sel(trig_sel), .arm(arm), .ready(ready), .valid(valid),
      .mem_addr(mem_addr), .mem_en(mem_en), .trig_addr(trig_addr),
      .start_addr(start_addr), .bank_sel(bank_sel), .trigger_state(trigger_state),
      .waiting_for_trigger(waiting_for_trigger), .triggered(triggered),
      .auto_fired(auto_fired)
   );

   always #5 clk = ~clk;

   typedef struct {
      int trig;
      int start;
      int af;
      int pre;
      int fill;
   } cap_t;

   cap_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic wait_state(input int st, input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (int'(trigger_state) != st && n < budget);
      chk(tag, int'(trigger_state), st);
   endtask

   task automatic handshake(input int bank_after, input string tag);
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      chk({tag, "_bank"}, int'(bank_sel), bank_after);
      chk({tag, "_valid_drop"}, int'(valid), 0);
   endtask

   // write counters per phase, and scoreboard pop on each valid rise
   initial begin
      int   prev_state = 7;
      int   prev_valid = 0;
      int   pre_w = 0;
      int   fill_w = 0;
      cap_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_state = 7;
            prev_valid = 0;
         end else begin
            if (trigger_state == 3'd1 && prev_state != 1) pre_w = 0;
            if (trigger_state == 3'd3 && prev_state != 3) fill_w = 0;
            if (mem_en && trigger_state == 3'd1) pre_w++;
            if (mem_en && trigger_state == 3'd3) fill_w++;
            if (valid && prev_valid == 0) begin
               if (sb.size() == 0) begin
                  chk("sb_unexpected_valid", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("cap_trig_addr", int'(trig_addr), e.trig);
                  chk("cap_start_addr", int'(start_addr), e.start);
                  chk("cap_auto_fired", int'(auto_fired), e.af);
                  chk("cap_pre_writes", pre_w, e.pre);
                  chk("cap_fill_writes", fill_w, e.fill);
                  chk("cap_total_writes", pre_w + 1 + fill_w, 1 << DEPTH);
               end
            end
            prev_state = int'(trigger_state);
            prev_valid = int'(valid);
         end
      end
   end

   initial begin
      int cnt, bad, last, pulses;
      rst_n          = 1'b0;
      sample_divider = '0;
      mode           = 2'd0;
      pre_count      = 4'd5;
      auto_timeout   = '0;
      trigger_req    = '0;
      trig_sel       = 2'd2;
      arm            = 1'b0;
      ready          = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rst_state", int'(trigger_state), 1);
      chk("rst_valid", int'(valid), 0);
      chk("rst_mem_en", int'(mem_en), 1);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_bank", int'(bank_sel), 0);
      chk("rst_trig_addr", int'(trig_addr), 0);
      chk("rst_auto_fired", int'(auto_fired), 0);
      chk("rst_waiting", int'(waiting_for_trigger), 0);
      chk("rst_triggered", int'(triggered), 0);

      // normal mode, ch2 request lands on WAIT_TRIG strobe 9
      sb.push_back('{trig: 14, start: 9, af: 0, pre: 5, fill: 10});
      wait_state(2, 50, "t1_enter_wait");
      repeat (8) @(negedge clk);
      trigger_req = 3'b100;
      @(negedge clk);
      chk("t1_still_waiting", int'(waiting_for_trigger), 1);
      chk("t1_trig_sample_addr", int'(mem_addr), 14);
      wait_state(3, 10, "t1_enter_fill");
      trigger_req = '0;
      wait_state(4, 100, "t1_enter_read");
      chk("t1_triggered", int'(triggered), 1);
      chk("t1_bank_before", int'(bank_sel), 0);
      mode      = 2'd2;
      pre_count = 4'd0;
      sb.push_back('{trig: 0, start: 0, af: 0, pre: 0, fill: 15});
      handshake(1, "t1");
      chk("t1_to_prebuf", int'(trigger_state), 1);

      // immediate mode with no pre-trigger depth
      wait_state(4, 100, "t2_enter_read");
      mode         = 2'd1;
      auto_timeout = 8'd3;
      pre_count    = 4'd2;
      sb.push_back('{trig: 5, start: 3, af: 1, pre: 2, fill: 13});
      handshake(0, "t2");

      // auto timeout fires on the 4th WAIT_TRIG strobe
      wait_state(4, 100, "t3_enter_read");
      auto_timeout = 8'd0;
      pre_count    = 4'd3;
      trigger_req  = 3'b100;
      sb.push_back('{trig: 3, start: 0, af: 0, pre: 3, fill: 12});
      handshake(1, "t3");

      // request and auto timeout on the same strobe
      wait_state(4, 100, "t3b_enter_read");
      mode = 2'd3;
      handshake(0, "t3b");
      chk("t4_idle", int'(trigger_state), 0);

      // single mode: idle with no writes until arm
      sample_divider = 8'd2;
      pre_count      = 4'd4;
      trig_sel       = 2'd3;
      trigger_req    = 3'b111;
      cnt = 0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (mem_en) cnt++;
         if (trigger_state != 3'd0) bad++;
      end
      chk("t4_idle_writes", cnt, 0);
      chk("t4_idle_left", bad, 0);
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      chk("t4_arm_prebuf", int'(trigger_state), 1);
      chk("t4_arm_addr", int'(mem_addr), 0);
      mode = 2'd0;

      // divider 2 spacing, and an out-of-range select never triggers
      wait_state(2, 100, "t5_enter_wait");
      last   = -1;
      pulses = 0;
      bad    = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mem_en) begin
            if (last >= 0 && i - last != 3) bad++;
            last = i;
            pulses++;
         end
      end
      chk("t5_strobe_count", pulses, 10);
      chk("t5_strobe_gaps", bad, 0);
      chk("t5_no_trigger", int'(waiting_for_trigger), 1);

      // reset in the middle of FILL aborts the capture
      trig_sel = 2'd2;
      wait_state(3, 20, "t6_enter_fill");
      chk("t6_triggered", int'(triggered), 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_state", int'(trigger_state), 1);
      chk("t6_rst_valid", int'(valid), 0);
      chk("t6_rst_bank", int'(bank_sel), 0);
      chk("t6_rst_trig_addr", int'(trig_addr), 0);
      chk("t6_rst_auto_fired", int'(auto_fired), 0);
      chk("t6_rst_mem_addr", int'(mem_addr), 0);
      chk("t6_rst_triggered", int'(triggered), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got %0d checks expected completion", n_chk);
      $fatal(1);
   end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Multi-channel, parametrised capture controller for the DSO ADC front end. Generates the sample strobe, writes a circular capture buffer with a programmable pre-trigger depth, selects one of several trigger sources, supports normal/auto/immediate/single modes, and hands the filled bank to the SPI readout through a ready/valid handshake with bank swap. Sits between the ADC/trigger comparators and the dual-bank buffer memory; the ADC-to-memory data path is external.

## Interface
- DEPTH, 11, buffer address width; buffer holds N = 2^DEPTH samples
- DEL_W, 24, sample divider width
- NCH, 4, number of trigger request inputs (>= 2)
- CH_W, 2, trigger select width, = clog2(NCH)
- AUTO_W, 16, auto-trigger timeout counter width

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_divider  in  DEL_W  sample rate = clk / (1 + sample_divider)
- mode  in  2  0 normal, 1 auto, 2 immediate, 3 single
- pre_count  in  DEPTH  samples to keep before trigger sample
- auto_timeout  in  AUTO_W  strobes in WAIT_TRIG before auto forces trigger
- trigger_req  in  NCH  per-channel trigger condition met
- trig_sel  in  CH_W  selects trigger_req bit; values >= NCH never trigger
- arm  in  1  single-mode rearm pulse
- ready  in  1  consumer ready
- valid  out  1  captured bank complete
- mem_addr  out  DEPTH  write address
- mem_en  out  1  write strobe
- trig_addr  out  DEPTH  address holding the trigger sample
- start_addr  out  DEPTH  address of oldest sample, = trig_addr - pre_count mod N
- bank_sel  out  1  active write bank
- trigger_state  out  3  current state encoding
- waiting_for_trigger  out  1  state == WAIT_TRIG
- triggered  out  1  state is FILL or READ
- auto_fired  out  1  last capture triggered by auto timeout

## Operation
- Divider: div_q reloads sample_divider when zero, else decrements; sample_strobe = (div_q == 0). Divider free-runs in all states.
- trigger_req registered once (req_q); sel_req = req_q[trig_sel] (0 if trig_sel >= NCH).
- trigger_flag = sel_req | (mode == 2) | (mode == 1 & auto_cnt == auto_timeout).
- States: IDLE=0, PREBUF=1, WAIT_TRIG=2, FILL=3, READ=4.
- PREBUF: on entry addr = 0, pre_cnt = 0, pre_count latched to pre_q. Each strobe writes, addr++, pre_cnt++. When pre_cnt == pre_q -> WAIT_TRIG (pre_q = 0: next cycle).
- WAIT_TRIG: each strobe writes, addr++ (wraps mod N), auto_cnt++ (saturates). Trigger evaluated only on strobe cycles: if trigger_flag, that sample is written at addr, trig_addr <= addr, post_cnt cleared, auto_fired <= auto term alone caused it; -> FILL. auto_cnt cleared on WAIT_TRIG entry.
- FILL: each strobe writes, addr++ (wraps), post_cnt++. When post_cnt reaches N-1-pre_q -> READ (pre_q = N-1: leaves FILL after 0 writes, next cycle).
- READ: no writes; valid = 1. ready & valid: bank_sel toggles, -> IDLE if mode == 3, else -> PREBUF.
- IDLE: no writes; arm -> PREBUF.
- mem_en = sample_strobe & state in {PREBUF, WAIT_TRIG, FILL}; mem_addr = addr.
- mode, trig_sel sampled live; pre_count only at PREBUF entry.

## Timing
- Reset: state PREBUF, div_q 0, addr 0, trig_addr 0, bank_sel 0, auto_fired 0, req_q 0; valid 0, mem_en 1 in first cycle after release (div_q = 0).
- Trigger latency: trigger_req high at edge k is seen as sel_req after edge k+1; captured on first strobe at or after that.
- Total written per capture = N samples exactly (pre_q + 1 + N-1-pre_q, ignoring extra WAIT_TRIG overwrites).
- valid asserts the cycle after last FILL write; bank_sel toggles and valid drops on the edge where ready & valid.
- Reset mid-capture aborts immediately; no bank toggle.
- trigger and auto timeout on same strobe: auto_fired = 0.

## Test plan
- DEPTH=4, divider 0, pre_count 5, mode 0, trig on ch2 at strobe 9 of WAIT_TRIG -> trig_addr = 14, start_addr = 9, exactly 16 writes, valid, bank_sel 0->1 on ready.
- mode 2, pre_count 0 -> trigger on first WAIT_TRIG strobe, trig_addr 0, 15 FILL writes, auto_fired 0.
- mode 1, auto_timeout 3, no requests -> trigger on 4th WAIT_TRIG strobe, auto_fired 1.
- mode 3 -> after handshake state IDLE, mem_en 0 for 100 cycles; arm -> PREBUF, addr 0.
- divider 2 -> mem_en every 3rd cycle; trig_sel = NCH with all requests high -> never leaves WAIT_TRIG in mode 0.
- rst_n low during FILL -> outputs at reset values immediately, bank_sel unchanged at 0.
